icache_assoc: RTL and testbench
===============================

Name: icache_assoc

Overview:
- Parametrised successor to the direct-mapped vanilla instruction cache: a ways_p-way set-associative icache with per-way valid bits and a round-robin victim pointer per set.
- Block fills are staged in an in-order fill buffer, and the block is committed to the victim way on the last word.
- A sequential invalidation sweep runs on reset and on flush.
- Sits between the vanilla core fetch stage and the remote-load refill path; one-cycle read latency.

Parameters:
- tag_width_p, 12, tag bits per line.
- sets_p, 64, sets per way (power of 2, >=2).
- block_size_in_words_p, 4, words per line (power of 2, >=2).
- ways_p, 2, associativity (power of 2, 1..8).
- instr_width_p, 32, instruction word width.
- Derived: set_width = clog2(sets_p); offset_width = clog2(block_size_in_words_p); pc_width = tag_width_p + set_width + offset_width (word address).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset. Synchronous, active-low.
- v_i  in  1  fetch request; accepted when v_i & ready_o.
- pc_i  in  pc_width  fetch word address.
- ready_o  out  1  cache can accept a fetch this cycle.
- instr_v_o  out  1  instr_o/miss_o valid; response to the fetch accepted last cycle.
- instr_o  out  instr_width_p  fetched word; holds its value until the next accepted fetch.
- miss_o  out  1  no valid tag match for pc_r_o; qualified by instr_v_o.
- pc_r_o  out  pc_width  address of the last accepted fetch.
- fill_v_i  in  1  refill word valid.
- fill_pc_i  in  pc_width  refill word address.
- fill_instr_i  in  instr_width_p  refill word.
- fill_ready_o  out  1  refill word accepted when fill_v_i & fill_ready_o.
- flush_i  in  1  invalidate all lines (pulse).
- busy_o  out  1  invalidation sweep in progress.
- fill_err_o  out  1  sticky: an out-of-sequence fill word was seen; cleared only by reset.

Behaviour:
- Reset (reset_n_i=0 at a clock edge):
  - ready_o=0, instr_v_o=0, miss_o=0, pc_r_o=0, instr_o=0, fill_err_o=0, busy_o=1.
  - Fill offset counter=0; all rr pointers=0; FSM enters SWEEP.
- FSM states: SWEEP and READY.
- SWEEP:
  - Set counter runs from 0 to sets_p-1, clearing the valid bits of all ways of one set per cycle.
  - After writing set sets_p-1, go to READY. Total sweep length is exactly sets_p cycles.
  - ready_o=0 and fill_ready_o=0 throughout.
- READY:
  - busy_o=0; fill_ready_o=1.
  - ready_o=1, except in a cycle where a fill commit writes the arrays; ready_o=0 then.
- flush_i=1 in READY:
  - Next cycle enters SWEEP with counter 0.
  - The partially filled buffer is discarded (offset counter -> 0).
  - A fetch accepted in the same cycle still completes normally.
  - flush_i while already in SWEEP restarts the sweep at set 0.
- Fetch path:
  - On v_i&ready_o: pc_r_o<=pc_i, and all ways' tag/valid/data for set pc_i[offset_width+:set_width] are read.
  - Next cycle: instr_v_o=1, and the word is selected by pc_r_o[offset_width-1:0].
  - miss_o=1 iff no way has valid & tag==pc_r_o[msbs].
  - On a hit: instr_o = hit way's word. On a miss: instr_o = way 0's word (don't-care to the core).
  - Multiple tag matches are illegal (simulation assertion).
  - No accepted fetch: instr_v_o=0, and instr_o/pc_r_o/miss_o hold.
- Fill path:
  - Words must arrive in order, offsets 0..block_size-1, all with the same tag and set.
  - Offsets 0..block_size-2 are written into the buffer; the counter increments.
  - On the last offset the full line is committed to the victim way: tag written, valid=1. The counter wraps to 0.
  - Victim selection: lowest-index invalid way; if none, way rr[set], after which rr[set] increments modulo ways_p (wraps).
  - ways_p=1: the victim is always way 0.
  - A fill word whose offset != counter, or whose tag/set differs from word 0 of the line: dropped, counter -> 0, fill_err_o<=1.
- Simultaneous events:
  - A commit has priority over a fetch because ready_o is low.
  - A fetch to the set being committed in the following cycle sees the new line.
  - reset_n_i overrides everything, including mid-fill and mid-sweep.

Test Plan:
- Reset with sets_p=64: busy_o stays high for exactly 64 cycles after reset release; ready_o rises on cycle 65. A fetch to pc 0x000 then returns miss_o=1.
- Fill the line at pc 0x100..0x103 with words 0xA0..0xA3, then fetch 0x102: instr_v_o=1 and miss_o=0 on the next cycle, instr_o=0xA2. ready_o is 0 exactly in the commit cycle.
- ways_p=2: fill three lines with tags 1,2,3 into the same set. Tag 1 goes to way 0 and tag 2 to way 1; tag 3 evicts way 0 (rr). Fetching tag 1 then misses and fetching tag 2 hits.
- Send fill offsets 0,2 for one line: word 2 is dropped and fill_err_o=1 and stays set. A subsequent correct 0..3 fill commits normally.
- Send flush_i after two of four fill words: busy_o=1 for sets_p cycles. All previously hit addresses now miss, and a later fill starting at offset 0 succeeds.
- Hold reset_n_i low for one cycle mid-sweep and mid-fill: all outputs return to reset values, and a full sweep restarts from set 0.

Source files
------------

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with in-order block refill, round-robin
// replacement and a sequential valid-bit invalidation sweep on reset/flush.
module icache_assoc #(
    parameter int tag_width_p           = 12,
    parameter int sets_p                = 64,
    parameter int block_size_in_words_p = 4,
    parameter int ways_p                = 2,
    parameter int instr_width_p         = 32,
    localparam int set_width_lp         = $clog2(sets_p),
    localparam int offset_width_lp      = $clog2(block_size_in_words_p),
    localparam int pc_width_lp          = tag_width_p + set_width_lp + offset_width_lp
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    input  logic [pc_width_lp-1:0]   pc_i,
    output logic                     ready_o,
    output logic                     instr_v_o,
    output logic [instr_width_p-1:0] instr_o,
    output logic                     miss_o,
    output logic [pc_width_lp-1:0]   pc_r_o,
    input  logic                     fill_v_i,
    input  logic [pc_width_lp-1:0]   fill_pc_i,
    input  logic [instr_width_p-1:0] fill_instr_i,
    output logic                     fill_ready_o,
    input  logic                     flush_i,
    output logic                     busy_o,
    output logic                     fill_err_o
);

    localparam int way_w_lp = (ways_p > 1) ? $clog2(ways_p) : 1;
    localparam logic [offset_width_lp-1:0] last_off_lp = offset_width_lp'(block_size_in_words_p - 1);
    localparam logic [set_width_lp-1:0]    last_set_lp = set_width_lp'(sets_p - 1);

    typedef enum logic {SWEEP, READY} state_e;

    state_e                     state_q, state_d;
    logic [set_width_lp-1:0]    sweep_q, sweep_d;
    logic [offset_width_lp-1:0] fill_cnt_q, fill_cnt_d;
    logic                       fill_err_q, fill_err_d;
    logic [tag_width_p-1:0]     fill_tag_q;
    logic [set_width_lp-1:0]    fill_set_q;
    logic [instr_width_p-1:0]   fill_buf_q [block_size_in_words_p];
    logic [way_w_lp-1:0]        rr_q [sets_p];

    logic [ways_p-1:0]          valid_q [sets_p];
    logic [tag_width_p-1:0]     tag_q   [ways_p][sets_p];
    logic [instr_width_p-1:0]   data_q  [ways_p][sets_p][block_size_in_words_p];

    logic [pc_width_lp-1:0]     pc_r_q;
    logic [instr_width_p-1:0]   instr_q;
    logic                       miss_q, instr_v_q;

    logic [offset_width_lp-1:0] fetch_off, fill_off;
    logic [set_width_lp-1:0]    fetch_set, fill_set;
    logic [tag_width_p-1:0]     fetch_tag, fill_tag;
    logic                       fill_fire, fill_ok, commit, fetch_fire, free_found;
    logic [ways_p-1:0]          match;
    logic [instr_width_p-1:0]   hit_word;
    logic [way_w_lp-1:0]        victim, rr_next;

    assign fetch_off = pc_i[offset_width_lp-1:0];
    assign fetch_set = pc_i[offset_width_lp +: set_width_lp];
    assign fetch_tag = pc_i[offset_width_lp + set_width_lp +: tag_width_p];
    assign fill_off  = fill_pc_i[offset_width_lp-1:0];
    assign fill_set  = fill_pc_i[offset_width_lp +: set_width_lp];
    assign fill_tag  = fill_pc_i[offset_width_lp + set_width_lp +: tag_width_p];

    // Word 0 of a line establishes the tag/set that the remaining words must match.
    assign fill_fire  = fill_v_i && (state_q == READY);
    assign fill_ok    = (fill_off == fill_cnt_q) &&
                        ((fill_cnt_q == '0) || ((fill_tag == fill_tag_q) && (fill_set == fill_set_q)));
    assign commit     = fill_fire && fill_ok && (fill_off == last_off_lp);
    assign fetch_fire = v_i && ready_o;

    assign ready_o      = (state_q == READY) && !commit;
    assign fill_ready_o = (state_q == READY);
    assign busy_o       = (state_q == SWEEP);
    assign fill_err_o   = fill_err_q;
    assign instr_v_o    = instr_v_q;
    assign instr_o      = instr_q;
    assign miss_o       = miss_q;
    assign pc_r_o       = pc_r_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        match    = '0;
        hit_word = data_q[0][fetch_set][fetch_off];
        for (int w = 0; w < ways_p; w++) begin
            match[w] = valid_q[fetch_set][w] && (tag_q[w][fetch_set] == fetch_tag);
            if (match[w]) hit_word = data_q[w][fetch_set][fetch_off];
        end
    end

    always_comb begin
        victim     = rr_q[fill_set_q];
        free_found = 1'b0;
        for (int w = ways_p - 1; w >= 0; w--) begin
            if (!valid_q[fill_set_q][w]) begin
                victim     = way_w_lp'(w);
                free_found = 1'b1;
            end
        end
        rr_next = (ways_p == 1) ? '0 : rr_q[fill_set_q] + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        fill_cnt_d = fill_cnt_q;
        fill_err_d = fill_err_q;
        case (state_q)
            SWEEP: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == last_set_lp) state_d = READY;
            end
            READY: ;
            default: state_d = SWEEP;
        endcase
        if (fill_fire) begin
            if (!fill_ok) begin
                fill_cnt_d = '0;
                fill_err_d = 1'b1;
            end else if (commit) begin
                fill_cnt_d = '0;
            end else begin
                fill_cnt_d = fill_cnt_q + 1'b1;
            end
        end
        if (flush_i) begin
            state_d    = SWEEP;
            sweep_d    = '0;
            fill_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n_i) begin
            state_q    <= SWEEP;
            sweep_q    <= '0;
            fill_cnt_q <= '0;
            fill_err_q <= 1'b0;
            pc_r_q     <= '0;
            instr_q    <= '0;
            miss_q     <= 1'b0;
            instr_v_q  <= 1'b0;
            for (int s = 0; s < sets_p; s++) rr_q[s] <= '0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            fill_cnt_q <= fill_cnt_d;
            fill_err_q <= fill_err_d;
            instr_v_q  <= fetch_fire;
            if (fetch_fire) begin
                pc_r_q  <= pc_i;
                miss_q  <= ~|match;
                instr_q <= hit_word;
            end
            if (commit && !free_found) rr_q[fill_set_q] <= rr_next;
        end
    end

    // NOTE: storage arrays carry no reset; the invalidation sweep clears the valid bits instead.
    always_ff @(posedge clk_i) begin
        if (fill_fire && fill_ok) begin
            fill_buf_q[fill_off] <= fill_instr_i;
            if (fill_cnt_q == '0) begin
                fill_tag_q <= fill_tag;
                fill_set_q <= fill_set;
            end
        end
        if (state_q == SWEEP) begin
            valid_q[sweep_q] <= '0;
        end else if (commit) begin
            valid_q[fill_set_q][victim] <= 1'b1;
            tag_q[victim][fill_set_q]   <= fill_tag_q;
            for (int i = 0; i < block_size_in_words_p; i++) begin
                data_q[victim][fill_set_q][i] <= (i == block_size_in_words_p - 1) ? fill_instr_i
                                                                                   : fill_buf_q[i];
            end
        end
    end

    // Two ways holding the same tag in one set would make the hit word ambiguous.
    assert property (@(posedge clk_i) disable iff (!reset_n_i) fetch_fire |-> $onehot0(match));

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: vector table for fetch/fill/replacement,
// hand-written sequences for sweep length, flush and reset during activity.
module tb_icache_assoc;

    localparam int PCW = 20;

    logic            clk_i = 1'b0;
    logic            reset_n_i;
    logic            v_i;
    logic [PCW-1:0]  pc_i;
    logic            ready_o, instr_v_o, miss_o;
    logic [31:0]     instr_o;
    logic [PCW-1:0]  pc_r_o;
    logic            fill_v_i;
    logic [PCW-1:0]  fill_pc_i;
    logic [31:0]     fill_instr_i;
    logic            fill_ready_o, flush_i, busy_o, fill_err_o;

    int errors = 0;
    int checks = 0;

    icache_assoc dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .pc_i(pc_i),
        .ready_o(ready_o), .instr_v_o(instr_v_o), .instr_o(instr_o), .miss_o(miss_o),
        .pc_r_o(pc_r_o), .fill_v_i(fill_v_i), .fill_pc_i(fill_pc_i),
        .fill_instr_i(fill_instr_i), .fill_ready_o(fill_ready_o), .flush_i(flush_i),
        .busy_o(busy_o), .fill_err_o(fill_err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic           v;
        logic [PCW-1:0] pc;
        logic           fv;
        logic [PCW-1:0] fpc;
        logic [31:0]    fdata;
        logic           flush;
        logic           exp_ready;
        logic           exp_iv;
        logic           exp_miss;
        logic [31:0]    exp_instr;
        logic           chk_instr;
        logic           exp_err;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t fe(input logic [PCW-1:0] pc, input logic miss,
                                input logic [31:0] instr, input logic err);
        vec_t t;
        t = '{v: 1'b1, pc: pc, fv: 1'b0, fpc: '0, fdata: '0, flush: 1'b0, exp_ready: 1'b1,
              exp_iv: 1'b1, exp_miss: miss, exp_instr: instr, chk_instr: !miss, exp_err: err};
        return t;
    endfunction

    function automatic vec_t fl(input logic [PCW-1:0] base, input int k,
                                input logic [31:0] dbase, input logic err);
        vec_t t;
        t = '{v: 1'b0, pc: '0, fv: 1'b1, fpc: base + PCW'(k), fdata: dbase + 32'(k), flush: 1'b0,
              exp_ready: (k != 3), exp_iv: 1'b0, exp_miss: 1'b0, exp_instr: '0, chk_instr: 1'b0,
              exp_err: err};
        return t;
    endfunction

    task automatic run_vec(input vec_t t, input string tag);
        @(negedge clk_i);
        v_i = t.v; pc_i = t.pc; fill_v_i = t.fv; fill_pc_i = t.fpc;
        fill_instr_i = t.fdata; flush_i = t.flush;
        #1;
        check({tag, " ready"}, 64'(ready_o), 64'(t.exp_ready));
        @(posedge clk_i);
        #1;
        check({tag, " instr_v"}, 64'(instr_v_o), 64'(t.exp_iv));
        if (t.exp_iv) begin
            check({tag, " miss"}, 64'(miss_o), 64'(t.exp_miss));
            check({tag, " pc_r"}, 64'(pc_r_o), 64'(t.pc));
            if (t.chk_instr) check({tag, " instr"}, 64'(instr_o), 64'(t.exp_instr));
        end
        check({tag, " fill_err"}, 64'(fill_err_o), 64'(t.exp_err));
        v_i = 1'b0; fill_v_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic count_busy(input string name);
        int n = 0;
        check({name, " ready during sweep"}, 64'(ready_o), 64'(0));
        check({name, " fill_ready during sweep"}, 64'(fill_ready_o), 64'(0));
        while (busy_o && n < 200) begin
            n++;
            @(posedge clk_i);
            #1;
        end
        check({name, " busy cycles"}, 64'(n), 64'(64));
        check({name, " ready after sweep"}, 64'(ready_o), 64'(1));
        check({name, " fill_ready after sweep"}, 64'(fill_ready_o), 64'(1));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " ready"}, 64'(ready_o), 64'(0));
        check({name, " instr_v"}, 64'(instr_v_o), 64'(0));
        check({name, " miss"}, 64'(miss_o), 64'(0));
        check({name, " pc_r"}, 64'(pc_r_o), 64'(0));
        check({name, " instr"}, 64'(instr_o), 64'(0));
        check({name, " fill_err"}, 64'(fill_err_o), 64'(0));
        check({name, " busy"}, 64'(busy_o), 64'(1));
    endtask

    initial begin
        vec_t tbl[$];
        vec_t t;

        reset_n_i = 1'b0; v_i = 1'b0; pc_i = '0; fill_v_i = 1'b0; fill_pc_i = '0;
        fill_instr_i = '0; flush_i = 1'b0;

        // Table: tag 1 in set 0, then tags 2,3,4 exercise free-way and round-robin victims.
        tbl.push_back(fe(20'h000, 1'b1, 32'h0, 1'b0));
        t = fe(20'h000, 1'b0, 32'h0, 1'b0);
        t.v = 1'b0; t.exp_iv = 1'b0;
        tbl.push_back(t);
        for (int k = 0; k < 4; k++) tbl.push_back(fl(20'h100, k, 32'hA0, 1'b0));
        tbl.push_back(fe(20'h102, 1'b0, 32'hA2, 1'b0));
        for (int k = 0; k < 4; k++) tbl.push_back(fl(20'h200, k, 32'hB0, 1'b0));
        tbl.push_back(fe(20'h101, 1'b0, 32'hA1, 1'b0));
        for (int k = 0; k < 4; k++) tbl.push_back(fl(20'h300, k, 32'hC0, 1'b0));
        tbl.push_back(fe(20'h302, 1'b0, 32'hC2, 1'b0));
        tbl.push_back(fe(20'h101, 1'b1, 32'h0, 1'b0));
        tbl.push_back(fe(20'h201, 1'b0, 32'hB1, 1'b0));
        for (int k = 0; k < 3; k++) tbl.push_back(fl(20'h400, k, 32'hD0, 1'b0));
        t = fl(20'h400, 3, 32'hD0, 1'b0);
        t.v = 1'b1; t.pc = 20'h101;
        tbl.push_back(t);
        tbl.push_back(fe(20'h201, 1'b1, 32'h0, 1'b0));
        tbl.push_back(fe(20'h400, 1'b0, 32'hD0, 1'b0));
        tbl.push_back(fe(20'h302, 1'b0, 32'hC2, 1'b0));
        // Out-of-order word sets the sticky error; a clean refill still commits.
        tbl.push_back(fl(20'h504, 0, 32'hE0, 1'b0));
        tbl.push_back(fl(20'h504, 2, 32'hE0, 1'b1));
        for (int k = 0; k < 4; k++) tbl.push_back(fl(20'h504, k, 32'hF0, 1'b1));
        tbl.push_back(fe(20'h505, 1'b0, 32'hF1, 1'b1));

        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("in reset");
        check("in reset fill_ready", 64'(fill_ready_o), 64'(0));
        @(negedge clk_i);
        reset_n_i = 1'b1;
        count_busy("initial sweep");

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Flush with a half-filled line and a concurrent fetch.
        run_vec(fl(20'h700, 0, 32'h70, 1'b1), "flush pre0");
        run_vec(fl(20'h700, 1, 32'h70, 1'b1), "flush pre1");
        t = fe(20'h505, 1'b0, 32'hF1, 1'b1);
        t.flush = 1'b1;
        run_vec(t, "flush cycle");
        count_busy("flush sweep");
        run_vec(fe(20'h302, 1'b1, 32'h0, 1'b1), "post flush 302");
        run_vec(fe(20'h400, 1'b1, 32'h0, 1'b1), "post flush 400");
        run_vec(fe(20'h505, 1'b1, 32'h0, 1'b1), "post flush 505");
        for (int k = 0; k < 4; k++) run_vec(fl(20'h700, k, 32'h70, 1'b1), $sformatf("refill700_%0d", k));
        run_vec(fe(20'h702, 1'b0, 32'h72, 1'b1), "fetch 702");

        // Reset mid-fill, then again mid-sweep.
        run_vec(fl(20'h800, 0, 32'h80, 1'b1), "midfill0");
        t = fl(20'h800, 1, 32'h80, 1'b1);
        t.v = 1'b1; t.pc = 20'h702; t.exp_iv = 1'b1; t.exp_instr = 32'h72; t.chk_instr = 1'b1;
        run_vec(t, "midfill1");
        @(negedge clk_i);
        reset_n_i = 1'b0;
        @(posedge clk_i);
        #1;
        check_reset_outputs("reset midfill");
        @(negedge clk_i);
        reset_n_i = 1'b1;
        repeat (10) @(posedge clk_i);
        #1;
        check("midsweep busy", 64'(busy_o), 64'(1));
        @(negedge clk_i);
        reset_n_i = 1'b0;
        @(posedge clk_i);
        #1;
        check_reset_outputs("reset midsweep");
        @(negedge clk_i);
        reset_n_i = 1'b1;
        count_busy("restarted sweep");
        for (int k = 0; k < 4; k++) run_vec(fl(20'h800, k, 32'h80, 1'b0), $sformatf("fill800_%0d", k));
        run_vec(fe(20'h802, 1'b0, 32'h82, 1'b0), "fetch 802");
        run_vec(fe(20'h702, 1'b1, 32'h0, 1'b0), "fetch 702 after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
